// File: rtl/mem_target.sv
// Memory target: a byte RAM behind a request/acknowledge handshake with
// programmable wait states, an address range check and a sticky bus error.
module mem_target #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_dir,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      mem_in,
  output logic [WIDTH-1:0]      mem_out,
  output logic                  mem_ack,
  output logic                  busy,
  output logic                  bus_error
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_dir;
  logic [WIDTH-1:0]      lat_data;
  logic [3:0]            wait_cnt;
  logic [WIDTH-1:0]      ram [DEPTH];

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_dir;
  logic [WIDTH-1:0]      cur_data;
  logic [IDX_W-1:0]      idx;
  logic                  mapped;
  logic                  latch_en;
  logic                  enter_ack;
  logic                  ram_we;
  logic                  rd_en;
  logic                  ack_next;
  logic                  busy_next;

  // Transaction attributes: with zero wait states the access happens on the
  // same edge that latches the request, so take them straight from the bus.
  always_comb begin
    cur_addr = lat_addr;
    cur_dir  = lat_dir;
    cur_data = lat_data;
    if (state == IDLE) begin
      cur_addr = addr;
      cur_dir  = mem_dir;
      cur_data = mem_in;
    end
    mapped = (32'(cur_addr) < DEPTH);
    idx    = cur_addr[IDX_W-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mem_req) begin
          next_state = (WAIT_STATES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = ACK;
        end
      end
      ACK: begin
        next_state = RELEASE;
      end
      RELEASE: begin
        if (!mem_req) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output/control decode; the handshake outputs are registered below.
  always_comb begin
    latch_en  = (state == IDLE) && mem_req;
    enter_ack = (next_state == ACK) && (state != ACK);
    ram_we    = enter_ack && !cur_dir && mapped && !reset;
    rd_en     = enter_ack && cur_dir;
    ack_next  = (next_state == ACK);
    busy_next = (next_state != IDLE);
  end

  // Request latch, wait counter, read data and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_dir   <= 1'b0;
      lat_data  <= '0;
      wait_cnt  <= 4'd0;
      mem_out   <= '0;
      mem_ack   <= 1'b0;
      busy      <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      mem_ack <= ack_next;
      busy    <= busy_next;
      if (latch_en) begin
        lat_addr <= addr;
        lat_dir  <= mem_dir;
        lat_data <= mem_in;
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (rd_en) begin
        mem_out <= mapped ? ram[idx] : '1;
      end
      if (enter_ack && !mapped) begin
        bus_error <= 1'b1;
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= cur_data;
    end
  end

endmodule

// File: tb/tb_mem_target.sv
// Bench for mem_target: table-driven transactions on a 2-wait-state instance
// with a scoreboard checked at every acknowledge, plus hand-written sequences
// for reset abort and a zero-wait-state instance.
module tb_mem_target;

  localparam int unsigned WS = 2;

  typedef struct {
    logic        dir;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        scramble;
    logic        early;
    int          hold;
    logic [7:0]  exp_out;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] exp_out;
    logic       exp_err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_dir;
  logic [15:0] addr;
  logic [7:0]  mem_in;
  logic [7:0]  mem_out;
  logic        mem_ack;
  logic        busy;
  logic        bus_error;

  logic        req0;
  logic        dir0;
  logic [15:0] addr0;
  logic [7:0]  in0;
  logic [7:0]  out0;
  logic        ack0;
  logic        busy0;
  logic        err0;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t vecs[13];

  mem_target #(.WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_dir(mem_dir), .addr(addr),
    .mem_in(mem_in), .mem_out(mem_out), .mem_ack(mem_ack), .busy(busy),
    .bus_error(bus_error)
  );

  mem_target #(.WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_req(req0), .mem_dir(dir0), .addr(addr0),
    .mem_in(in0), .mem_out(out0), .mem_ack(ack0), .busy(busy0),
    .bus_error(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every acknowledge must match the oldest outstanding request.
  always @(posedge clk) begin
    exp_t rec;
    #1;
    if (mem_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        rec = sb_q.pop_front();
        check("mem_out", 32'(mem_out), 32'(rec.exp_out));
        check("bus_error", 32'(bus_error), 32'(rec.exp_err));
      end
    end
  end

  task automatic txn(input vec_t v);
    int lat;
    bit got;
    @(negedge clk);
    mem_req = 1'b1;
    mem_dir = v.dir;
    addr    = v.addr;
    mem_in  = v.data;
    sb_q.push_back('{v.exp_out, v.exp_err});
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mem_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      if (v.scramble) begin
        addr   = 16'($urandom);
        mem_in = 8'($urandom);
      end
      if (v.early) mem_req = 1'b0;
      @(posedge clk);
      lat++;
    end
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(lat), 32'(WS));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      #1;
      check("busy_held", 32'(busy), 32'd1);
    end
    @(negedge clk);
    mem_req = 1'b0;
    @(posedge clk);
    if (v.hold == 0) begin
      #1;
      check("busy_release", 32'(busy), 32'd1);
      @(posedge clk);
    end
    #1;
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           dir   addr      data   scr   early hold exp_out err
    vecs[0]  = '{1'b0, 16'h0010, 8'h5A, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 8, 8'h5A, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 8'h11, 1'b0, 1'b0, 0, 8'h5A, 1'b0};
    vecs[3]  = '{1'b0, 16'h00FF, 8'hC3, 1'b0, 1'b0, 2, 8'h5A, 1'b0};
    vecs[4]  = '{1'b1, 16'h00FF, 8'h00, 1'b0, 1'b0, 0, 8'hC3, 1'b0};
    vecs[5]  = '{1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1, 8'h11, 1'b0};
    vecs[6]  = '{1'b0, 16'h0010, 8'h77, 1'b1, 1'b0, 0, 8'h11, 1'b0};
    vecs[7]  = '{1'b1, 16'h0010, 8'h00, 1'b1, 1'b0, 0, 8'h77, 1'b0};
    vecs[8]  = '{1'b0, 16'h0100, 8'h33, 1'b0, 1'b0, 0, 8'h77, 1'b1};
    vecs[9]  = '{1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 0, 8'h11, 1'b1};
    vecs[10] = '{1'b1, 16'h0100, 8'h00, 1'b0, 1'b0, 0, 8'hFF, 1'b1};
    vecs[11] = '{1'b0, 16'h0020, 8'hBB, 1'b0, 1'b0, 0, 8'hFF, 1'b1};
    vecs[12] = '{1'b1, 16'h00FF, 8'h00, 1'b0, 1'b1, 0, 8'hC3, 1'b1};

    reset = 1'b1;
    mem_req = 1'b0; mem_dir = 1'b0; addr = '0; mem_in = '0;
    req0 = 1'b0; dir0 = 1'b0; addr0 = '0; in0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(mem_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(bus_error), 32'd0);
    check("rst_out", 32'(mem_out), 32'd0);
    check("rst_ack0", 32'(ack0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) txn(vecs[i]);

    // Reset during the wait phase of a write: abort, nothing committed.
    @(negedge clk);
    mem_req = 1'b1; mem_dir = 1'b0; addr = 16'h0020; mem_in = 8'hAA;
    @(posedge clk);
    #1;
    check("abort_busy_wait", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ack", 32'(mem_ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(bus_error), 32'd0);
    check("abort_out", 32'(mem_out), 32'd0);
    @(posedge clk);
    #1;
    check("reset_beats_req", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_req = 1'b0;
    txn('{1'b1, 16'h0020, 8'h00, 1'b0, 1'b0, 0, 8'hBB, 1'b0});
    txn('{1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 0, 8'h77, 1'b0});

    // Zero wait states: acknowledge on the cycle right after sampling.
    @(negedge clk);
    req0 = 1'b1; dir0 = 1'b0; addr0 = 16'h0005; in0 = 8'h3C;
    @(posedge clk);
    #1;
    check("zw_wr_ack", 32'(ack0), 32'd1);
    check("zw_wr_busy", 32'(busy0), 32'd1);
    check("zw_wr_out", 32'(out0), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk);
    #1;
    check("zw_wr_ack_single", 32'(ack0), 32'd0);
    check("zw_wr_release", 32'(busy0), 32'd1);
    @(posedge clk);
    #1;
    check("zw_wr_idle", 32'(busy0), 32'd0);
    @(negedge clk);
    req0 = 1'b1; dir0 = 1'b1; addr0 = 16'h0005; in0 = 8'h00;
    @(posedge clk);
    #1;
    check("zw_rd_ack", 32'(ack0), 32'd1);
    check("zw_rd_out", 32'(out0), 32'h3C);
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk);
    #1;
    check("zw_rd_ack_single", 32'(ack0), 32'd0);
    check("zw_rd_out_hold", 32'(out0), 32'h3C);
    check("zw_err", 32'(err0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
